// File: rtl/readout_sequencer_if.sv
// ---------------------------------------------------------------------------
// readout_sequencer_if
// Downstream sample stream of the readout sequencer.
//   out_data  : sample captured from the selected channel
//   out_chan  : index of the channel that supplied out_data
//   out_valid : sample present, held until accepted
//   out_ready : sink accepts; a transfer happens when valid and ready are both 1
// Modports: master = sequencer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface readout_sequencer_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] out_data;
    logic [3:0]       out_chan;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, out_chan, out_valid, input out_ready);
    modport slave  (input out_data, out_chan, out_valid, output out_ready);
endinterface

// File: rtl/readout_sequencer.sv
// ---------------------------------------------------------------------------
// readout_sequencer
// Walks the enabled channels of one event in ascending order, requests each
// digitizer, waits for it, then streams its samples until the channel
// reports done. One sample per 3 cycles at best (PRESENT + 2 SETTLE cycles).
//
// Parameters: NCH (channels, 1..16), WIDTH (sample bits), TMO (timeout cycles)
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, chan_mask      : event request and channel enables (sampled on accept)
//   ro_enable, rodone_n   : per-channel ready / done (active-low) status
//   ch_data               : channel i sample on [i*WIDTH +: WIDTH]
//   read_request          : one-hot request to the channel being served
//   spi_done              : one-cycle "sample consumed" pulse to that channel
//   out_if (master)       : downstream valid/ready sample stream
//   busy, err             : event in progress / sticky timeout flag
//
// Optional feature: define READOUT_TIMEOUT_EN to build the REQUEST/PRESENT
// timeout counter; otherwise err is tied low and both states wait forever.
// ---------------------------------------------------------------------------
module readout_sequencer #(
    parameter int NCH   = 4,
    parameter int WIDTH = 12,
    parameter int TMO   = 1023
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NCH-1:0]       chan_mask,
    input  logic [NCH-1:0]       ro_enable,
    input  logic [NCH-1:0]       rodone_n,
    input  logic [NCH*WIDTH-1:0] ch_data,
    output logic [NCH-1:0]       read_request,
    output logic [NCH-1:0]       spi_done,
    readout_sequencer_if.master  out_if,
    output logic                 busy,
    output logic                 err
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {IDLE, SELECT, REQUEST, SETTLE, PRESENT, NEXT} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic             settle_q, settle_d;
    logic             done_q;
    logic [WIDTH-1:0] out_data_q;
    logic [3:0]       out_chan_q;

    logic             accept, xfer, capture, tmo_hit, tmo_fire;
    logic [PW-1:0]    sel_ptr;
    logic             sel_found;
    logic [NCH-1:0]   ptr_onehot;
    logic             sel_en, sel_done_n;
    logic [WIDTH-1:0] sel_data;

    // Per-channel views of the channel under ptr, plus the next enabled
    // channel at or above ptr (scan from the top so the lowest index wins).
    always_comb begin
        sel_ptr    = ptr_q;
        sel_found  = 1'b0;
        ptr_onehot = '0;
        sel_en     = 1'b0;
        sel_done_n = 1'b1;
        sel_data   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i >= int'(ptr_q))) begin
                sel_ptr   = PW'(i);
                sel_found = 1'b1;
            end
            if (ptr_q == PW'(i)) begin
                ptr_onehot[i] = 1'b1;
                sel_en        = ro_enable[i];
                sel_done_n    = rodone_n[i];
                sel_data      = ch_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state_q == IDLE) && start && (chan_mask != '0);

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned -- that is what keeps latches out.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mask_d   = mask_q;
        settle_d = 1'b0;
        capture  = 1'b0;
        xfer     = 1'b0;
        tmo_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SELECT;
                    ptr_d   = '0;
                    mask_d  = chan_mask;
                end
            end
            SELECT: begin
                if (sel_found) begin
                    ptr_d   = sel_ptr;
                    state_d = REQUEST;
                end else begin
                    state_d = IDLE;
                end
            end
            REQUEST: begin
                if (sel_en) begin
                    state_d = SETTLE;
                end else if (tmo_hit) begin
                    state_d  = NEXT;
                    tmo_fire = 1'b1;
                end
            end
            SETTLE: begin
                if (!settle_q) begin
                    settle_d = 1'b1;
                end else if (!sel_done_n || !sel_en) begin
                    state_d = NEXT;
                end else begin
                    capture = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_if.out_ready) begin
                    xfer    = 1'b1;
                    state_d = SETTLE;
                end else if (tmo_hit) begin
                    state_d  = NEXT;
                    tmo_fire = 1'b1;
                end
            end
            NEXT: begin
                if (ptr_q == PW'(NCH - 1)) begin
                    state_d = IDLE;
                end else begin
                    ptr_d   = ptr_q + PW'(1);
                    state_d = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            mask_q     <= '0;
            settle_q   <= 1'b0;
            done_q     <= 1'b0;
            out_data_q <= '0;
            out_chan_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            settle_q <= settle_d;
            done_q   <= xfer;
            if (capture) begin
                out_data_q <= sel_data;
                out_chan_q <= 4'(ptr_q);
            end
        end
    end

`ifdef READOUT_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          err_q;

    // Fires on the TMO-th consecutive cycle spent waiting in one state.
    assign tmo_hit = ((state_q == REQUEST) || (state_q == PRESENT)) &&
                     (tmo_cnt_q == TW'(TMO - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == REQUEST) || (state_q == PRESENT)) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (tmo_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    // Timeout compiled out: keep TMO and the hook referenced, err stays low.
    logic tmo_unused;
    assign tmo_hit    = 1'b0;
    assign tmo_unused = tmo_fire | (TMO == 0);
    assign err        = 1'b0;
`endif

    // The request stays up from REQUEST through PRESENT and drops in NEXT.
    assign read_request = ((state_q == REQUEST) || (state_q == SETTLE) ||
                           (state_q == PRESENT)) ? ptr_onehot : '0;
    assign spi_done     = done_q ? ptr_onehot : '0;
    assign busy         = (state_q != IDLE);

    assign out_if.out_valid = (state_q == PRESENT);
    assign out_if.out_data  = out_data_q;
    assign out_if.out_chan  = out_chan_q;
endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 NCH, 4, number of single-channel digitizers served (1..16).
REQ-002 WIDTH, 12, sample width in bits.
REQ-003 TMO, 1023, timeout limit in clk cycles; used only when READOUT_TIMEOUT_EN is defined.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse requesting readout of one event.
REQ-007 chan_mask  input  NCH  channel enable; bit i = 1 means channel i is read.
REQ-008 ro_enable  input  NCH  per-channel readout-enable status.
REQ-009 rodone_n  input  NCH  per-channel readout done, active-low.
REQ-010 ch_data  input  NCH*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
REQ-011 read_request  output  NCH  one-hot readout request to the selected channel.
REQ-012 spi_done  output  NCH  one-cycle pulse telling the selected channel that its sample was consumed.
REQ-013 out_data  output  WIDTH  sample to downstream.
REQ-014 out_chan  output  4  index of the channel that supplied out_data.
REQ-015 out_valid  output  1, and out_ready  input  1: valid/ready handshake; a transfer occurs when both are 1.
REQ-016 busy  output  1  high from acceptance of start until the return to IDLE.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 The FSM states SHALL be IDLE, SELECT, REQUEST, SETTLE, PRESENT and NEXT, using a channel pointer ptr.
REQ-019 IDLE: start with chan_mask != 0 -> SELECT with ptr=0, busy=1; start with chan_mask == 0 is ignored.
REQ-020 start received while busy=1 SHALL be ignored and not queued.
REQ-021 chan_mask SHALL be sampled on start acceptance; later changes have no effect on the current event.
REQ-022 SELECT: ptr moves to the lowest enabled index >= ptr within one cycle, then -> REQUEST; if no enabled index remains -> IDLE.
REQ-023 REQUEST and every later state up to NEXT: read_request[ptr]=1, all other bits 0.
REQ-024 REQUEST: hold until ro_enable[ptr]=1, then -> SETTLE.
REQ-025 SETTLE: lasts exactly 2 cycles, then:
  - rodone_n[ptr]=0 or ro_enable[ptr]=0 -> NEXT;
  - otherwise capture ch_data slice ptr into out_data, set out_chan=ptr -> PRESENT.
REQ-026 PRESENT: out_valid=1. out_data and out_chan stay stable and out_valid stays high until a transfer.
REQ-027 On the transfer cycle T: out_valid=0 at T+1; spi_done[ptr]=1 for exactly the cycle T+1; -> SETTLE.
REQ-028 Maximum throughput SHALL be one sample per 3 cycles; out_ready tied 1 yields exactly 3 cycles per sample.
REQ-029 NEXT: read_request=0 for one cycle, ptr+1 -> SELECT; if ptr = NCH-1 -> IDLE.
REQ-030 On return to IDLE, busy=0 in the same cycle that IDLE is entered.
REQ-031 At most one spi_done bit and one read_request bit SHALL be high in any cycle.

Reset
REQ-032 When reset_n=0, the block SHALL immediately enter IDLE with ptr=0.
REQ-033 When reset_n=0, every output SHALL be 0: read_request, spi_done, out_data, out_chan, out_valid, busy, err.
REQ-034 Reset asserted mid-event SHALL abort the event with no spi_done pulse; after release the block waits for a new start.

Configuration
REQ-035 With READOUT_TIMEOUT_EN defined:
  - a cycle counter, cleared on every state change, counts cycles spent in REQUEST or PRESENT;
  - reaching TMO sets err=1, drops out_valid without a transfer and forces NEXT;
  - err is cleared only by reset or an accepted start.
REQ-036 Without READOUT_TIMEOUT_EN: no counter is built, err is constant 0, and REQUEST/PRESENT wait indefinitely.

Verification
REQ-037 NCH=4, mask=4'b0101, each channel returns 3 samples then rodone_n=0, out_ready=1:
  - out_chan sequence 0,0,0,2,2,2;
  - samples 3 cycles apart;
  - spi_done[0] pulses 3 times, spi_done[2] pulses 3 times;
  - busy falls after channel 2.
REQ-038 Backpressure: out_ready=0 for 10 cycles while PRESENT -> out_data stable, out_valid high, no spi_done; single transfer when out_ready rises.
REQ-039 start with mask=0 -> busy stays 0; a second start while busy -> event count unchanged.
REQ-040 Assert reset_n=0 while in PRESENT on channel 1 -> all outputs 0 next edge, no spi_done; a fresh start then restarts at channel 0.
REQ-041 READOUT_TIMEOUT_EN, TMO=20, channel 1 ro_enable held 0 -> err=1 after 20 cycles in REQUEST; channel 2 still read; err cleared by next start.
REQ-042 Channel with rodone_n already 0 when ro_enable rises -> zero samples output, moves to next channel.
